// File: rtl/rst_seq.sv
// Reset sequencer: holds all reset outputs until PLL lock has been stable,
// then releases them one by one (bit 0 first) with a fixed stagger.
// Lock loss, a debounced button press, a software request or a watchdog
// expiry restarts the sequence and records the cause.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_HOLD  | all resets asserted, counting consecutive lock-high cycles
// S_STAGE | bit 0 released, remaining bits released every STAGGER_CYCLES
// S_RUN   | all resets released, o_ready high, watchdog active
module rst_seq #(
   parameter int NUM_OUT         = 2,
   parameter int HOLD_CYCLES     = 33554431,
   parameter int STAGGER_CYCLES  = 16,
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int WDT_CYCLES      = 0
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_lock,
   input  logic               i_btn,
   input  logic               i_sw_req,
   input  logic               i_wdt_kick,
   output logic [NUM_OUT-1:0] o_rst,
   output logic               o_ready,
   output logic [1:0]         o_cause
);

   localparam int HOLD_W = (HOLD_CYCLES     > 1) ? $clog2(HOLD_CYCLES)     : 1;
   localparam int STG_W  = (STAGGER_CYCLES  > 1) ? $clog2(STAGGER_CYCLES)  : 1;
   localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int WDT_W  = (WDT_CYCLES      > 1) ? $clog2(WDT_CYCLES)      : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(STAGGER_CYCLES - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [WDT_W-1:0]  WDT_LAST  = WDT_W'((WDT_CYCLES > 0) ? WDT_CYCLES - 1 : 0);
   localparam bit                WDT_EN    = (WDT_CYCLES > 0);

   localparam logic [1:0] CAUSE_POR = 2'd0;
   localparam logic [1:0] CAUSE_BTN = 2'd1;
   localparam logic [1:0] CAUSE_SW  = 2'd2;
   localparam logic [1:0] CAUSE_WDT = 2'd3;

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_STAGE = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [STG_W-1:0]   stg_cnt_q, stg_cnt_d;
   logic [WDT_W-1:0]   wdt_cnt_q, wdt_cnt_d;
   logic [NUM_OUT-1:0] o_rst_q, o_rst_d;
   logic               ready_q, ready_d;
   logic [1:0]         cause_q, cause_d;

   logic               btn_s1_q, btn_s1_d;
   logic               btn_s2_q, btn_s2_d;
   logic               btn_db_q, btn_db_d;
   logic [DEB_W-1:0]   db_cnt_q, db_cnt_d;
   logic               btn_evt_q, btn_evt_d;

   logic               wdt_expire;
   logic [NUM_OUT-1:0] rst_shift;

   // button synchroniser and debouncer; a registered pulse marks each press
   always_comb begin
      btn_s1_d  = i_btn;
      btn_s2_d  = btn_s1_q;
      btn_db_d  = btn_db_q;
      db_cnt_d  = db_cnt_q;
      btn_evt_d = 1'b0;
      if (btn_s2_q != btn_db_q) begin
         if (db_cnt_q == DEB_LAST) begin
            btn_db_d  = btn_s2_q;
            db_cnt_d  = '0;
            btn_evt_d = btn_s2_q;
         end else if (db_cnt_q != '1) begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end else begin
         db_cnt_d = '0;
      end
   end

   // sequencing FSM: triggers first (lock > wdt > button > sw), then per-state work
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      stg_cnt_d  = stg_cnt_q;
      wdt_cnt_d  = wdt_cnt_q;
      o_rst_d    = o_rst_q;
      ready_d    = ready_q;
      cause_d    = cause_q;
      // releasing shifts zeros in from bit 0, so the mask empties top-last
      rst_shift  = o_rst_q << 1;
      wdt_expire = WDT_EN && (state_q == S_RUN) && !i_wdt_kick && (wdt_cnt_q == WDT_LAST);

      if (!i_lock || wdt_expire || btn_evt_q || i_sw_req) begin
         state_d    = S_HOLD;
         hold_cnt_d = '0;
         stg_cnt_d  = '0;
         wdt_cnt_d  = '0;
         o_rst_d    = '1;
         ready_d    = 1'b0;
         if (!i_lock)         cause_d = CAUSE_POR;
         else if (wdt_expire) cause_d = CAUSE_WDT;
         else if (btn_evt_q)  cause_d = CAUSE_BTN;
         else                 cause_d = CAUSE_SW;
      end else begin
         case (state_q)
            S_HOLD: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  hold_cnt_d = '0;
                  stg_cnt_d  = '0;
                  o_rst_d    = rst_shift;
                  if (rst_shift == '0) begin
                     state_d   = S_RUN;
                     ready_d   = 1'b1;
                     wdt_cnt_d = '0;
                  end else begin
                     state_d = S_STAGE;
                  end
               end else if (hold_cnt_q != '1) begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            S_STAGE: begin
               if (stg_cnt_q == STG_LAST) begin
                  stg_cnt_d = '0;
                  o_rst_d   = rst_shift;
                  if (rst_shift == '0) begin
                     state_d   = S_RUN;
                     ready_d   = 1'b1;
                     wdt_cnt_d = '0;
                  end
               end else if (stg_cnt_q != '1) begin
                  stg_cnt_d = stg_cnt_q + 1'b1;
               end
            end
            S_RUN: begin
               if (WDT_EN) begin
                  if (i_wdt_kick)              wdt_cnt_d = '0;
                  else if (wdt_cnt_q != '1)    wdt_cnt_d = wdt_cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = S_HOLD;
            end
         endcase
      end
   end

   // state and counter registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q    <= S_HOLD;
         hold_cnt_q <= '0;
         stg_cnt_q  <= '0;
         wdt_cnt_q  <= '0;
         o_rst_q    <= '1;
         ready_q    <= 1'b0;
         cause_q    <= CAUSE_POR;
         btn_s1_q   <= 1'b0;
         btn_s2_q   <= 1'b0;
         btn_db_q   <= 1'b0;
         db_cnt_q   <= '0;
         btn_evt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         stg_cnt_q  <= stg_cnt_d;
         wdt_cnt_q  <= wdt_cnt_d;
         o_rst_q    <= o_rst_d;
         ready_q    <= ready_d;
         cause_q    <= cause_d;
         btn_s1_q   <= btn_s1_d;
         btn_s2_q   <= btn_s2_d;
         btn_db_q   <= btn_db_d;
         db_cnt_q   <= db_cnt_d;
         btn_evt_q  <= btn_evt_d;
      end
   end

   assign o_rst   = o_rst_q;
   assign o_ready = ready_q;
   assign o_cause = cause_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: directed scenarios plus random stimulus, every cycle
// compared against a cycle-count model of the release/trigger rules.
module tb_rst_seq;

   localparam int N    = 3;
   localparam int H    = 8;
   localparam int S    = 4;
   localparam int D    = 4;
   localparam int W    = 20;
   localparam int FULL = H + (N - 1) * S;

   logic         i_clk = 1'b0;
   logic         i_rstn = 1'b0;
   logic         i_lock = 1'b0;
   logic         i_btn = 1'b0;
   logic         i_sw_req = 1'b0;
   logic         i_wdt_kick = 1'b0;
   logic [N-1:0] o_rst;
   logic         o_ready;
   logic [1:0]   o_cause;

   int n_chk  = 0;
   int n_fail = 0;

   // model: consecutive qualifying lock-high cycles since the last restart
   int m_cnt   = 0;
   int m_idle  = 0;
   int m_cause = 0;
   int m_run   = 0;
   bit m_b1    = 0;
   bit m_b2    = 0;
   bit m_db    = 0;
   bit m_evt   = 0;

   rst_seq #(
      .NUM_OUT(N),
      .HOLD_CYCLES(H),
      .STAGGER_CYCLES(S),
      .DEBOUNCE_CYCLES(D),
      .WDT_CYCLES(W)
   ) dut (
      .i_clk(i_clk),
      .i_rstn(i_rstn),
      .i_lock(i_lock),
      .i_btn(i_btn),
      .i_sw_req(i_sw_req),
      .i_wdt_kick(i_wdt_kick),
      .o_rst(o_rst),
      .o_ready(o_ready),
      .o_cause(o_cause)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] exp_rst();
      logic [N-1:0] r;
      for (int k = 0; k < N; k++) r[k] = (m_cnt < H + k * S);
      return r;
   endfunction

   task automatic model_edge(input bit rstn, input bit lock, input bit btn, input bit sw, input bit kick);
      bit evt_now;
      bit running;
      bit expire;
      if (!rstn) begin
         m_cnt = 0; m_idle = 0; m_cause = 0; m_run = 0;
         m_b1 = 0; m_b2 = 0; m_db = 0; m_evt = 0;
         return;
      end
      evt_now = m_evt;
      m_evt   = 0;
      if (m_b2 != m_db) begin
         m_run++;
         if (m_run == D) begin
            m_db  = m_b2;
            m_run = 0;
            m_evt = m_db;
         end
      end else begin
         m_run = 0;
      end
      m_b2 = m_b1;
      m_b1 = btn;
      running = (m_cnt >= FULL);
      expire  = running && !kick && (m_idle == W - 1);
      if (!lock) begin
         m_cause = 0; m_cnt = 0; m_idle = 0;
      end else if (expire) begin
         m_cause = 3; m_cnt = 0; m_idle = 0;
      end else if (evt_now) begin
         m_cause = 1; m_cnt = 0; m_idle = 0;
      end else if (sw) begin
         m_cause = 2; m_cnt = 0; m_idle = 0;
      end else if (running) begin
         m_idle = kick ? 0 : m_idle + 1;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic cyc(input bit rstn, input bit lock, input bit btn, input bit sw, input bit kick);
      i_rstn = rstn; i_lock = lock; i_btn = btn; i_sw_req = sw; i_wdt_kick = kick;
      @(posedge i_clk);
      model_edge(rstn, lock, btn, sw, kick);
      @(negedge i_clk);
      chk("o_rst", 32'(o_rst), 32'(exp_rst()));
      chk("o_ready", 32'(o_ready), 32'(m_cnt >= FULL));
      chk("o_cause", 32'(o_cause), 32'(m_cause));
   endtask

   task automatic run_until_ready(input int max_cyc);
      int k;
      k = 0;
      while (m_cnt < FULL && k < max_cyc) begin
         cyc(1, 1, 0, 0, 1);
         k++;
      end
      chk("ready_within_budget", 32'(o_ready), 32'd1);
   endtask

   initial begin
      bit seen;
      bit btn_lvl;
      int btn_left;

      // reset
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("reset_o_rst", 32'(o_rst), 32'b111);
      chk("reset_ready", 32'(o_ready), 32'd0);
      chk("reset_cause", 32'(o_cause), 32'd0);

      // plain release sequence
      for (int i = 1; i <= 18; i++) begin
         cyc(1, 1, 0, 0, 0);
         if (i == 7)  chk("release_e7", 32'(o_rst), 32'b111);
         if (i == 8)  chk("release_e8", 32'(o_rst), 32'b110);
         if (i == 12) chk("release_e12", 32'(o_rst), 32'b100);
         if (i == 15) chk("ready_e15", 32'(o_ready), 32'd0);
         if (i == 16) begin
            chk("release_e16", 32'(o_rst), 32'b000);
            chk("ready_e16", 32'(o_ready), 32'd1);
            chk("cause_e16", 32'(o_cause), 32'd0);
         end
      end

      // serviced watchdog keeps the system running
      for (int j = 0; j < 200; j++) begin
         cyc(1, 1, 0, 0, (j % 10) == 0);
         chk("wdt_kicked_ready", 32'(o_ready), 32'd1);
      end

      // unserviced watchdog expires after W cycles
      cyc(1, 1, 0, 0, 1);
      for (int j = 0; j < W - 1; j++) cyc(1, 1, 0, 0, 0);
      chk("wdt_before_expiry", 32'(o_ready), 32'd1);
      cyc(1, 1, 0, 0, 0);
      chk("wdt_expiry_rst", 32'(o_rst), 32'b111);
      chk("wdt_expiry_cause", 32'(o_cause), 32'd3);

      // lock loss in the middle of staging
      for (int i = 1; i <= 9; i++) cyc(1, 1, 0, 0, 0);
      chk("stage_before_loss", 32'(o_rst), 32'b110);
      cyc(1, 0, 0, 0, 0);
      chk("lockloss_rst", 32'(o_rst), 32'b111);
      chk("lockloss_ready", 32'(o_ready), 32'd0);
      chk("lockloss_cause", 32'(o_cause), 32'd0);
      for (int i = 1; i <= 16; i++) begin
         cyc(1, 1, 0, 0, 1);
         if (i == 15) chk("relock_e15", 32'(o_ready), 32'd0);
         if (i == 16) chk("relock_e16", 32'(o_ready), 32'd1);
      end

      // short button glitch is filtered
      for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 1);
      for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 1);
      chk("btn_short_ready", 32'(o_ready), 32'd1);
      chk("btn_short_cause", 32'(o_cause), 32'd0);

      // held button restarts with cause 1
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1, 1, 0, 1);
         if (o_rst == 3'b111 && o_cause == 2'd1) seen = 1;
      end
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1, 0, 0, 1);
         if (o_rst == 3'b111 && o_cause == 2'd1) seen = 1;
      end
      chk("btn_long_restart", 32'(seen), 32'd1);
      run_until_ready(40);
      chk("btn_cause_kept", 32'(o_cause), 32'd1);

      // software request in the expiry cycle loses to the watchdog
      cyc(1, 1, 0, 0, 1);
      for (int j = 0; j < W - 1; j++) cyc(1, 1, 0, 0, 0);
      cyc(1, 1, 0, 1, 0);
      chk("prio_wdt_over_sw", 32'(o_cause), 32'd3);
      run_until_ready(40);

      // software request alone
      cyc(1, 1, 0, 1, 1);
      chk("sw_rst", 32'(o_rst), 32'b111);
      chk("sw_cause", 32'(o_cause), 32'd2);
      run_until_ready(40);

      // synchronous reset while running
      cyc(0, 1, 0, 0, 1);
      chk("midreset_rst", 32'(o_rst), 32'b111);
      chk("midreset_ready", 32'(o_ready), 32'd0);
      chk("midreset_cause", 32'(o_cause), 32'd0);

      // random stimulus against the model
      btn_lvl  = 0;
      btn_left = 0;
      for (int c = 0; c < 4000; c++) begin
         if (btn_left == 0) begin
            btn_lvl  = 1'($urandom_range(0, 1));
            btn_left = $urandom_range(1, 12);
         end
         btn_left--;
         cyc($urandom_range(0, 299) != 0,
             $urandom_range(0, 63) != 0,
             btn_lvl,
             $urandom_range(0, 99) == 0,
             $urandom_range(0, 11) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
